// File: rtl/vga_timing_gen.sv
// VGA/VESA raster timing generator.
// Pixel/line counters advance under pix_en. Every output is a flop whose D input
// is decoded from the *next* counter values, so syncs, blanking and strobes stay
// cycle-aligned with pixel_x/pixel_y without adding a pipeline stage.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          video_on,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          video_on_q, video_on_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Next raster position: x wraps at end of line, y steps only on that wrap.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Decode from next position; with pix_en=0 the next position equals the
  // current one, so the decoded flags hold by construction.
  always_comb begin
    video_on_d    = (x_d < H_ACT) && (y_d < V_ACT);
    hblank_d      = (x_d >= H_ACT);
    vblank_d      = (y_d >= V_ACT);
    hsync_d       = ((x_d >= H_SYNC_BEG) && (x_d <= H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((y_d >= V_SYNC_BEG) && (y_d <= V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d  = pix_en && (x_q == H_LAST);
    frame_start_d = pix_en && (x_q == H_LAST) && (y_q == V_LAST);
  end

  // State registers; reset parks the raster on the last pixel of the frame so
  // the first enable lands exactly on (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      video_on_q    <= 1'b0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign video_on    = video_on_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default 640x480 timing, a tiny
// raster for whole-frame behaviour, and 800x600 with active-high syncs) driven
// from a table of directed vectors, plus hand sequences for periods, a 1-in-4
// enable pattern and a mid-frame reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        vo;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } out_t;

  typedef struct {
    int    sel;
    int    n;
    logic  en;
    out_t  exp;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // default 640x480 instance
  logic [10:0] d_x, d_y;
  logic d_vo, d_hb, d_vb, d_hs, d_vs, d_ls, d_fs;
  vga_timing_gen dut_def (
    .clk(clk), .rst_n(rst_n), .pix_en(en0),
    .pixel_x(d_x), .pixel_y(d_y), .video_on(d_vo), .hblank(d_hb), .vblank(d_vb),
    .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
  );

  // tiny raster: H 6/2/3/2 (13), V 5/2/2/3 (12), active-high syncs, 4-bit counters
  logic [3:0] s_x, s_y;
  logic s_vo, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs;
  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)
  ) dut_sm (
    .clk(clk), .rst_n(rst_n), .pix_en(en1),
    .pixel_x(s_x), .pixel_y(s_y), .video_on(s_vo), .hblank(s_hb), .vblank(s_vb),
    .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
  );

  // 800x600@60: H 800/40/128/88 (1056), V 600/1/4/23 (628), active-high syncs
  logic [10:0] v_x, v_y;
  logic v_vo, v_hb, v_vb, v_hs, v_vs, v_ls, v_fs;
  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(11)
  ) dut_svga (
    .clk(clk), .rst_n(rst_n), .pix_en(en2),
    .pixel_x(v_x), .pixel_y(v_y), .video_on(v_vo), .hblank(v_hb), .vblank(v_vb),
    .hsync(v_hs), .vsync(v_vs), .line_start(v_ls), .frame_start(v_fs)
  );

  function automatic out_t mo(int x, int y, bit vo, bit hb, bit vb, bit hs, bit vs, bit ls, bit fs);
    out_t o;
    o.x = 11'(x); o.y = 11'(y);
    o.vo = vo; o.hb = hb; o.vb = vb; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic out_t cur(int sel);
    out_t o;
    case (sel)
      1:       o = '{x: {7'd0, s_x}, y: {7'd0, s_y}, vo: s_vo, hb: s_hb, vb: s_vb, hs: s_hs, vs: s_vs, ls: s_ls, fs: s_fs};
      2:       o = '{x: v_x, y: v_y, vo: v_vo, hb: v_hb, vb: v_vb, hs: v_hs, vs: v_vs, ls: v_ls, fs: v_fs};
      default: o = '{x: d_x, y: d_y, vo: d_vo, hb: d_hb, vb: d_vb, hs: d_hs, vs: d_vs, ls: d_ls, fs: d_fs};
    endcase
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(string name, out_t got, out_t exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got x=%0d y=%0d vo/hb/vb/hs/vs/ls/fs=%b%b%b%b%b%b%b, expected x=%0d y=%0d vo/hb/vb/hs/vs/ls/fs=%b%b%b%b%b%b%b",
               name, got.x, got.y, got.vo, got.hb, got.vb, got.hs, got.vs, got.ls, got.fs,
               exp.x, exp.y, exp.vo, exp.hb, exp.vb, exp.hs, exp.vs, exp.ls, exp.fs);
    end else begin
      $display("[TB] ok %s: x=%0d y=%0d", name, got.x, got.y);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("[TB] ok %s: %0d", name, got);
    end
  endtask

  vec_t vecs[$];

  task automatic add(int sel, int n, logic en, out_t exp, string name);
    vec_t v;
    v.sel = sel; v.n = n; v.en = en; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    int t;
    int hs_low, ls_cnt, x_changes, wide;
    logic prev_ls;
    logic [10:0] prev_x;

    // Columns: sel, clocks, pix_en, expected {x, y, vo, hb, vb, hs, vs, ls, fs}
    add(0, 0,   1'b0, mo(799, 524, 0, 1, 1, 1, 1, 0, 0), "def_reset");
    add(1, 0,   1'b0, mo(12,  11,  0, 1, 1, 0, 0, 0, 0), "sm_reset");
    add(2, 0,   1'b0, mo(1055, 627, 0, 1, 1, 0, 0, 0, 0), "svga_reset");
    add(0, 1,   1'b1, mo(0,   0,   1, 0, 0, 1, 1, 1, 1), "def_first_enable");
    add(0, 1,   1'b1, mo(1,   0,   1, 0, 0, 1, 1, 0, 0), "def_strobes_clear");
    add(0, 638, 1'b1, mo(639, 0,   1, 0, 0, 1, 1, 0, 0), "def_last_active");
    add(0, 1,   1'b1, mo(640, 0,   0, 1, 0, 1, 1, 0, 0), "def_hblank_start");
    add(0, 15,  1'b1, mo(655, 0,   0, 1, 0, 1, 1, 0, 0), "def_pre_hsync");
    add(0, 1,   1'b1, mo(656, 0,   0, 1, 0, 0, 1, 0, 0), "def_hsync_first");
    add(0, 95,  1'b1, mo(751, 0,   0, 1, 0, 0, 1, 0, 0), "def_hsync_last");
    add(0, 1,   1'b1, mo(752, 0,   0, 1, 0, 1, 1, 0, 0), "def_hsync_end");
    add(0, 47,  1'b1, mo(799, 0,   0, 1, 0, 1, 1, 0, 0), "def_line_end");
    add(0, 1,   1'b1, mo(0,   1,   1, 0, 0, 1, 1, 1, 0), "def_line2_start");
    add(0, 3,   1'b0, mo(0,   1,   1, 0, 0, 1, 1, 0, 0), "def_hold_idle");
    add(0, 1,   1'b1, mo(1,   1,   1, 0, 0, 1, 1, 0, 0), "def_resume");
    add(1, 1,   1'b1, mo(0,   0,   1, 0, 0, 0, 0, 1, 1), "sm_first");
    add(1, 13,  1'b1, mo(0,   1,   1, 0, 0, 0, 0, 1, 0), "sm_line1");
    add(1, 52,  1'b1, mo(0,   5,   0, 0, 1, 0, 0, 1, 0), "sm_vblank_start");
    add(1, 26,  1'b1, mo(0,   7,   0, 0, 1, 0, 1, 1, 0), "sm_vsync_first");
    add(1, 8,   1'b1, mo(8,   7,   0, 1, 1, 1, 1, 0, 0), "sm_hsync_on");
    add(1, 3,   1'b1, mo(11,  7,   0, 1, 1, 0, 1, 0, 0), "sm_hsync_off");
    add(1, 2,   1'b1, mo(0,   8,   0, 0, 1, 0, 1, 1, 0), "sm_vsync_last");
    add(1, 13,  1'b1, mo(0,   9,   0, 0, 1, 0, 0, 1, 0), "sm_vsync_end");
    add(1, 38,  1'b1, mo(12,  11,  0, 1, 1, 0, 0, 0, 0), "sm_frame_end");
    add(1, 1,   1'b1, mo(0,   0,   1, 0, 0, 0, 0, 1, 1), "sm_frame_wrap");
    add(2, 1,   1'b1, mo(0,   0,   1, 0, 0, 0, 0, 1, 1), "svga_first");
    add(2, 840, 1'b1, mo(840, 0,   0, 1, 0, 1, 0, 0, 0), "svga_hsync_first");
    add(2, 127, 1'b1, mo(967, 0,   0, 1, 0, 1, 0, 0, 0), "svga_hsync_last");
    add(2, 1,   1'b1, mo(968, 0,   0, 1, 0, 0, 0, 0, 0), "svga_hsync_end");
    add(2, 88,  1'b1, mo(0,   1,   1, 0, 0, 0, 0, 1, 0), "svga_line_wrap");

    // Reset for 5 clocks with every enable low.
    rst_n = 1'b0;
    @(negedge clk);
    repeat (5) step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].sel)
        1:       en1 = vecs[i].en;
        2:       en2 = vecs[i].en;
        default: en0 = vecs[i].en;
      endcase
      repeat (vecs[i].n) step();
      en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
      check(vecs[i].name, cur(vecs[i].sel), vecs[i].exp);
    end

    // line_start period with continuous enable.
    en0 = 1'b1;
    t = 0;
    while (!d_ls && t < 2000) begin step(); t++; end
    check_int("def_first_line_start_seen", int'(d_ls), 1);
    t = 0;
    do begin step(); t++; end while (!d_ls && t < 2000);
    check_int("def_line_start_period", t, 800);

    // 1-in-4 enable over exactly one line, starting just after a line_start.
    hs_low = 0; ls_cnt = 0; x_changes = 0; wide = 0; prev_ls = d_ls;
    for (int k = 0; k < 3200; k++) begin
      en0 = (k % 4 == 0);
      prev_x = d_x;
      step();
      if (d_ls) ls_cnt++;
      if (d_ls && prev_ls) wide++;
      if (!d_hs) hs_low++;
      if (d_x != prev_x) x_changes++;
      prev_ls = d_ls;
    end
    en0 = 1'b0;
    check_int("slow_hsync_width", hs_low, 384);
    check_int("slow_line_start_count", ls_cnt, 1);
    check_int("slow_wide_strobes", wide, 0);
    check_int("slow_x_steps", x_changes, 800);
    check_int("slow_x_end", int'(d_x), 0);

    // Mid-frame reset at x=300 with pix_en still high.
    en0 = 1'b1;
    t = 0;
    while (d_x != 11'd300 && t < 1000) begin step(); t++; end
    check_int("def_reach_x300", int'(d_x), 300);
    rst_n = 1'b0;
    step();
    check("def_midframe_reset", cur(0), mo(799, 524, 0, 1, 1, 1, 1, 0, 0));
    rst_n = 1'b1;
    step();
    check("def_after_reset", cur(0), mo(0, 0, 1, 0, 0, 1, 1, 1, 1));
    en0 = 1'b0;
    step();
    check("def_strobe_clear_idle", cur(0), mo(0, 0, 1, 0, 0, 1, 1, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
